// File: rtl/cpu_pkg.sv
// Shared constants for the LEGv8 pipeline: widths, reset PC and the bubble encoding.
package cpu_pkg;

    localparam int          ADDR_W    = 64;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [63:0] RESET_PC  = 64'h0;

endpackage : cpu_pkg

// File: rtl/branch_target.sv
// PC-relative target generator: pc + (sign-extended word offset << 2).
module branch_target #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_id,
    input  logic [18:0]       Imm19,
    input  logic [25:0]       Imm26,
    input  logic              UncondBr,
    output logic [ADDR_W-1:0] br_target
);

    logic [ADDR_W-1:0] off;

    // Select the offset field, sign-extend it, scale words to bytes and add (wraps modulo 2^ADDR_W).
    always_comb begin
        if (UncondBr) begin
            off = {{(ADDR_W-26){Imm26[25]}}, Imm26};
        end else begin
            off = {{(ADDR_W-19){Imm19[18]}}, Imm19};
        end
        br_target = pc_id + {off[ADDR_W-3:0], 2'b00};
    end

endmodule : branch_target

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux and the IF/ID pipeline register.
// One branch delay slot: the word fetched while a branch is in ID is never flushed.
module fetch_stage #(
    parameter int                        ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        BrTaken,
    input  logic                        UncondBr,
    input  logic [25:0]                 Imm26,
    input  logic [18:0]                 Imm19,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [cpu_pkg::INSTR_W-1:0] imem_instr,
    output logic [cpu_pkg::INSTR_W-1:0] instr_id,
    output logic [ADDR_W-1:0]           pc_id,
    output logic                        valid_id
);

    import cpu_pkg::INSTR_W;
    import cpu_pkg::NOP_INSTR;

    logic [ADDR_W-1:0]  pc_if_q,    pc_if_d;
    logic [INSTR_W-1:0] instr_id_q, instr_id_d;
    logic [ADDR_W-1:0]  pc_id_q,    pc_id_d;
    logic               valid_id_q, valid_id_d;
    logic [ADDR_W-1:0]  br_target;
    logic [ADDR_W-1:0]  pc_next;

    branch_target #(
        .ADDR_W (ADDR_W)
    ) u_branch_target (
        .pc_id     (pc_id_q),
        .Imm19     (Imm19),
        .Imm26     (Imm26),
        .UncondBr  (UncondBr),
        .br_target (br_target)
    );

    // Next-PC select keyed only on BrTaken so unused immediates cannot leak in; stall freezes everything.
    always_comb begin
        if (BrTaken) begin
            pc_next = br_target;
        end else begin
            pc_next = pc_if_q + ADDR_W'(4);
        end

        pc_if_d    = pc_if_q;
        instr_id_d = instr_id_q;
        pc_id_d    = pc_id_q;
        valid_id_d = valid_id_q;
        if (!stall) begin
            pc_if_d    = pc_next;
            instr_id_d = imem_instr;
            pc_id_d    = pc_if_q;
            valid_id_d = 1'b1;
        end
    end

    // PC and IF/ID state; reset forces a bubble into ID and restarts fetch at RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_if_q    <= RESET_PC[ADDR_W-1:0];
            instr_id_q <= NOP_INSTR;
            pc_id_q    <= '0;
            valid_id_q <= 1'b0;
        end else begin
            pc_if_q    <= pc_if_d;
            instr_id_q <= instr_id_d;
            pc_id_q    <= pc_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    assign imem_addr = pc_if_q;
    assign instr_id  = instr_id_q;
    assign pc_id     = pc_id_q;
    assign valid_id  = valid_id_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, B, B.cond, stall, X immediates, async reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        BrTaken;
    logic        UncondBr;
    logic [25:0] Imm26;
    logic [18:0] Imm19;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr_id;
    logic [63:0] pc_id;
    logic        valid_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory model: each word tags its own address.
    assign imem_instr = {16'hC0DE, imem_addr[15:0]};

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .BrTaken    (BrTaken),
        .UncondBr   (UncondBr),
        .Imm26      (Imm26),
        .Imm19      (Imm19),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .instr_id   (instr_id),
        .pc_id      (pc_id),
        .valid_id   (valid_id)
    );

    function automatic logic [31:0] iw(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock, then check the full IF/ID view against hand-computed values.
    task automatic step(input string tag, input logic [63:0] exp_pc_id, input logic [63:0] exp_addr);
        tick();
        check({tag, ".pc_id"},    pc_id,            exp_pc_id);
        check({tag, ".addr"},     imem_addr,        exp_addr);
        check({tag, ".instr"},    {32'h0, instr_id}, {32'h0, iw(exp_pc_id)});
        check({tag, ".valid"},    {63'h0, valid_id}, 64'h1);
        $display("step %s: pc_id=%0d imem_addr=%0d instr_id=%h", tag, pc_id, imem_addr, instr_id);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0; Imm26 = '0; Imm19 = '0;
        tick(); tick();
        check("rst.addr",  imem_addr, 64'h0);
        check("rst.valid", {63'h0, valid_id}, 64'h0);
        check("rst.instr", {32'h0, instr_id}, 64'h0);
        check("rst.pc_id", pc_id, 64'h0);
        $display("reset: imem_addr=%0d valid_id=%0b", imem_addr, valid_id);
        reset = 1'b0;

        // Sequential fetch
        step("e1", 0, 4);
        step("e2", 4, 8);
        step("e3", 8, 12);

        // B +4 words from PC 8 -> 24, delay slot at 12
        BrTaken = 1'b1; UncondBr = 1'b1; Imm26 = 26'd4;
        step("b_slot", 12, 24);
        BrTaken = 1'b0;
        step("b_tgt", 24, 28);
        step("b_tgt1", 28, 32);
        step("seq32", 32, 36);
        step("seq36", 36, 40);
        step("seq40", 40, 44);

        // B.cond -2 words from PC 40 -> 32
        BrTaken = 1'b1; UncondBr = 1'b0; Imm19 = 19'h7FFFE;
        step("bc_slot", 44, 32);
        BrTaken = 1'b0;
        step("bc_tgt", 32, 36);
        step("seq36b", 36, 40);
        step("seq40b", 40, 44);
        // Same immediate, not taken
        step("nt_44", 44, 48);
        step("nt_48", 48, 52);

        // B.cond -8 words from PC 48 -> 16
        BrTaken = 1'b1; UncondBr = 1'b0; Imm19 = 19'h7FFF8;
        step("neg_slot", 52, 16);
        BrTaken = 1'b0;
        step("neg_tgt", 16, 20);

        // Stall for 3 cycles with a taken B (+10 words -> 56) sitting in ID
        BrTaken = 1'b1; UncondBr = 1'b1; Imm26 = 26'd10; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall%0d", i), 16, 20);
        end
        stall = 1'b0;
        step("unstall", 20, 56);
        BrTaken = 1'b0;
        step("st_tgt", 56, 60);

        // Unused fields driven X while not taken
        UncondBr = 1'bx; Imm26 = 'x; Imm19 = 'x;
        step("x0", 60, 64);
        step("x1", 64, 68);

        // Async reset between edges while a taken branch is in ID
        BrTaken = 1'b1; UncondBr = 1'b1; Imm26 = 26'd100;
        #2 reset = 1'b1;
        #1;
        check("arst.addr",  imem_addr, 64'h0);
        check("arst.pc_id", pc_id, 64'h0);
        check("arst.valid", {63'h0, valid_id}, 64'h0);
        check("arst.instr", {32'h0, instr_id}, 64'h0);
        $display("async reset: imem_addr=%0d pc_id=%0d valid_id=%0b", imem_addr, pc_id, valid_id);
        tick();
        reset = 1'b0; BrTaken = 1'b0;
        step("rst_e1", 0, 4);
        step("rst_e2", 4, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
